rounder_flags: RTL and testbench
================================

ROUNDER_FLAGS -- requirements
Module: rounder_flags

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising-edge clock), rst_n input 1 (synchronous, active-low reset, sampled on the clk rising edge).
REQ-002 fr input 57 SHALL be the unrounded significand.
- fr[56] has weight 2^1 and fr[55] has weight 2^0.
- fr[54:0] is the fraction.
REQ-003 er input 13 SHALL be the unrounded exponent, two's complement, range -4096..4095.
REQ-004 db input 1 SHALL be the format select: 1 = double, 0 = single.
REQ-005 TINY output 1 SHALL be the registered tiny-before-rounding flag.
REQ-006 OVF1 output 1 SHALL be the registered exponent-overflow flag.
REQ-007 lz output 6 SHALL be the registered leading-zero count of the significand.

Function
REQ-008 The block SHALL compute lz as the number of leading zeros of fr[55:0], counted from bit 55 downward, range 0..56.
- If fr[56]=1, lz SHALL be 0.
- If fr[55:0]=0 and fr[56]=0, lz SHALL be 56.
REQ-009 emin SHALL be -1022 when db=1 and -126 when db=0.
REQ-010 emax SHALL be 1023 when db=1 and 127 when db=0.
REQ-011 The block SHALL compute TINY = 1 iff fr≠0 and (signed er - lz) < emin.
- The subtraction SHALL be at least 14-bit signed, so that no wrap occurs.
REQ-012 When fr is all-zero, TINY SHALL be 0.
REQ-013 The block SHALL compute OVF1 = 1 iff signed er > emax, independent of fr.
REQ-014 All three outputs SHALL be registered with exactly one cycle of latency.
- Inputs sampled at rising edge N appear on the outputs after edge N.
- There is no handshake.
- A new input set is accepted every cycle.
REQ-015 All comparisons SHALL use signed interpretation of er; er=13'h1FFF equals -1.
REQ-016 db SHALL affect only the emin/emax selection, never lz.
REQ-017 No output SHALL depend combinationally on any input.

Reset
REQ-018 While rst_n=0 at a rising clk edge, TINY, OVF1 and lz SHALL all be 0 after that edge, regardless of the inputs.
REQ-019 If reset is asserted mid-stream, the in-flight result SHALL be discarded, and outputs SHALL be 0 on the following cycle.
REQ-020 The first valid result after rst_n returns to 1 SHALL appear one cycle after the first non-reset edge.

Verification
REQ-021 fr=0, er=0, db=0 -> lz=56, TINY=0, OVF1=0 one cycle later.
REQ-022 fr=all ones, er=13'h1FFF (-1), db=0 -> lz=0, TINY=0, OVF1=0.
REQ-023 fr=57'b000011110000111100001111000011110000111100001111000011110, er=13'b0101010101010 (2730), db=1 -> lz=3, TINY=0, OVF1=1.
REQ-024 Zero and sign cases:
- fr=0, er=1, db=1 -> lz=56, TINY=0, OVF1=0.
- fr=57'h100000000000000 (bit 56 set), er=13'h1FFE (-2), db=0 -> lz=0, TINY=0, OVF1=0.
REQ-025 Boundary cases, all with fr bit 55 set only (lz=0):
- er=-126, db=0 -> TINY=0; er=-127, db=0 -> TINY=1.
- er=127, db=0 -> OVF1=0; er=128, db=0 -> OVF1=1; er=128, db=1 -> OVF1=0.
- er=-1022, db=1 -> TINY=0; er=-1023, db=1 -> TINY=1.
REQ-026 Reset and pipelining:
- Drive rst_n=0 for 2 cycles with the REQ-023 inputs applied -> all outputs 0.
- Release rst_n -> REQ-023 values appear one cycle later.
- Back-to-back differing inputs produce the matching per-cycle outputs with no bubbles.

Source files
------------

// File: rtl/rounder_flags.sv
// Rounding-stage flag generator.
// Takes an unrounded significand/exponent pair and produces, one cycle later:
//   lz   - leading-zero count of the significand (0 when the 2^1 bit is set)
//   TINY - value is nonzero and its normalised exponent falls below emin
//   OVF1 - raw exponent exceeds emax (independent of the significand)
// emin/emax follow the format select (double vs single). A fully pipelined
// stage with no handshake: a new input set is accepted every cycle.
module rounder_flags (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [56:0] fr,
  input  logic [12:0] er,
  input  logic        db,
  output logic        TINY,
  output logic        OVF1,
  output logic [5:0]  lz
);

  logic        [5:0]  lz_c;
  logic        [13:0] er_ext;
  logic        [13:0] lz_ext;
  logic signed [13:0] diff_c;
  logic signed [13:0] emin_c;
  logic signed [12:0] emax_c;
  logic               tiny_c;
  logic               ovf_c;

  // Priority leading-zero count over fr[55:0]; the highest set bit wins,
  // and a set integer bit fr[56] forces zero.
  always_comb begin
    lz_c = 6'd56;
    for (int i = 0; i < 56; i++) begin
      if (fr[i]) lz_c = 6'(55 - i);
    end
    if (fr[56]) lz_c = 6'd0;
  end

  // 14-bit signed arithmetic: er - lz spans -4152..4095, so no wrap is possible.
  assign er_ext = {er[12], er};
  assign lz_ext = {8'b0, lz_c};
  assign diff_c = $signed(er_ext) - $signed(lz_ext);

  assign emin_c = db ? -14'sd1022 : -14'sd126;
  assign emax_c = db ? 13'sd1023  : 13'sd127;

  // An all-zero significand is exact zero, never tiny.
  assign tiny_c = (|fr) && (diff_c < emin_c);
  assign ovf_c  = $signed(er) > emax_c;

  // Output register with synchronous active-low clear; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      TINY <= 1'b0;
      OVF1 <= 1'b0;
      lz   <= 6'd0;
    end else begin
      TINY <= tiny_c;
      OVF1 <= ovf_c;
      lz   <= lz_c;
    end
  end

endmodule

// File: tb/tb_rounder_flags.sv
// Directed table-driven bench for rounder_flags, plus reset and
// back-to-back pipelining sequences.
module tb_rounder_flags;

  logic        clk;
  logic        rst_n;
  logic [56:0] fr;
  logic [12:0] er;
  logic        db;
  logic        TINY;
  logic        OVF1;
  logic [5:0]  lz;

  rounder_flags dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fr   (fr),
    .er   (er),
    .db   (db),
    .TINY (TINY),
    .OVF1 (OVF1),
    .lz   (lz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [56:0] fr;
    logic [12:0] er;
    logic        db;
    logic [5:0]  lz;
    logic        tiny;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [56:0] FR_ALT = 57'b000011110000111100001111000011110000111100001111000011110;
  localparam logic [56:0] B55    = 57'h080000000000000;
  localparam logic [56:0] B56    = 57'h100000000000000;

  task automatic add_vec(input logic [56:0] f, input int e, input logic d,
                         input int l, input logic t, input logic o);
    vec_t v;
    v.fr = f; v.er = 13'(e); v.db = d;
    v.lz = 6'(l); v.tiny = t; v.ovf = o;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
  endtask

  task automatic check_outs(input string nm, input int idx, input vec_t v);
    check({nm, "_lz"},   idx, 64'(lz),   64'(v.lz));
    check({nm, "_tiny"}, idx, 64'(TINY), 64'(v.tiny));
    check({nm, "_ovf"},  idx, 64'(OVF1), 64'(v.ovf));
  endtask

  task automatic drive(input vec_t v);
    fr = v.fr; er = v.er; db = v.db;
  endtask

  initial begin
    vec_t zero_v;
    //       fr                   er     db  lz  T  O
    add_vec(57'd0,                0,     0,  56, 0, 0);
    add_vec({57{1'b1}},           -1,    0,  0,  0, 0);
    add_vec(FR_ALT,               2730,  1,  3,  0, 1);
    add_vec(57'd0,                1,     1,  56, 0, 0);
    add_vec(B56,                  -2,    0,  0,  0, 0);
    add_vec(B55,                  -126,  0,  0,  0, 0);
    add_vec(B55,                  -127,  0,  0,  1, 0);
    add_vec(B55,                  127,   0,  0,  0, 0);
    add_vec(B55,                  128,   0,  0,  0, 1);
    add_vec(B55,                  128,   1,  0,  0, 0);
    add_vec(B55,                  -1022, 1,  0,  0, 0);
    add_vec(B55,                  -1023, 1,  0,  1, 0);
    add_vec(57'd1 << 45,          -116,  0,  10, 0, 0);
    add_vec(57'd1 << 45,          -117,  0,  10, 1, 0);
    add_vec(57'd1,                0,     1,  55, 0, 0);
    add_vec(57'd1,                0,     0,  55, 0, 0);
    add_vec(57'd1,                -4096, 0,  55, 1, 0);
    add_vec(57'd0,                -4096, 1,  56, 0, 0);
    add_vec(57'd0,                4095,  1,  56, 0, 1);
    add_vec(B56 | 57'd1,          1023,  1,  0,  0, 0);
    add_vec(B56 | 57'd1,          1024,  1,  0,  0, 1);

    zero_v.fr = '0; zero_v.er = '0; zero_v.db = 1'b0;
    zero_v.lz = 6'd0; zero_v.tiny = 1'b0; zero_v.ovf = 1'b0;

    // Reset state with a nonzero input pattern applied.
    rst_n = 1'b0;
    drive(vecs[2]);
    repeat (2) @(posedge clk);
    #1 check_outs("reset_init", 0, zero_v);

    // Table: one vector per cycle, sampled 1 time unit after the capturing edge.
    @(negedge clk) rst_n = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk) drive(vecs[i]);
      @(posedge clk);
      #1 check_outs("vec", i, vecs[i]);
    end

    // Mid-stream reset: outputs currently hold the last vector; reset for 2 cycles.
    @(negedge clk) begin drive(vecs[2]); rst_n = 1'b0; end
    @(posedge clk);
    #1 check_outs("rst_mid", 0, zero_v);
    @(posedge clk);
    #1 check_outs("rst_mid", 1, zero_v);

    // Release: first result one cycle after the first non-reset edge.
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check_outs("rst_release", 0, vecs[2]);

    // Back-to-back: new input every negedge, previous input's result checked at the same time.
    @(negedge clk) drive(vecs[0]);
    for (int i = 1; i < vecs.size(); i++) begin
      @(negedge clk);
      check_outs("b2b", i - 1, vecs[i - 1]);
      drive(vecs[i]);
    end
    @(negedge clk);
    check_outs("b2b", vecs.size() - 1, vecs[vecs.size() - 1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
